// File: rtl/uart_rx_par.sv
// Oversampled UART receiver with 3-sample majority voting and a valid/ready output holding register.
// Optional parity support is built only when UART_RX_PARITY_EN is defined.
module uart_rx_par #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned STOP_BITS   = 1,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE / 2 - 2);
  localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_MODE > 2 ||
      OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0) begin : g_bad_param
    $error("uart_rx_par: illegal parameter value");
  end

  logic                 rx_meta_q, rx_sync_q;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [2:0]           bit_q, bit_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 maj, done, done_ferr, perr_calc;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = (PARITY_MODE != 0);
  localparam bit PAR_ODD = (PARITY_MODE == 2);
  logic par_bit_q, par_bit_d;
  logic parity_err_q, parity_err_d;
  // Even: data ^ parity must be 0; odd: must be 1.
  assign perr_calc  = PAR_EN ? ((^shift_q) ^ par_bit_q ^ PAR_ODD) : 1'b0;
  assign parity_err = parity_err_q;
`else
  assign perr_calc  = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) | (samp_q[1] & rx_sync_q);

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    ferr_acc_d  = ferr_acc_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = 1'b0;
    done        = 1'b0;
    done_ferr   = ferr_acc_q;
`ifdef UART_RX_PARITY_EN
    par_bit_d    = par_bit_q;
    parity_err_d = parity_err_q;
`endif
    if (b_tick) begin
      if (state_q != S_IDLE) begin
        tick_d = tick_q + TW'(1);
        if (tick_q == TICK_S0) samp_d[0] = rx_sync_q;
        if (tick_q == TICK_S1) samp_d[1] = rx_sync_q;
      end
      case (state_q)
        S_IDLE: begin
          if (!rx_sync_q) begin
            tick_d  = '0;
            state_d = S_START;
          end
        end
        S_START: begin
          if (tick_q == TICK_MID && maj) begin
            state_d = S_IDLE;
          end else if (tick_q == TICK_LAST) begin
            state_d    = S_DATA;
            tick_d     = '0;
            bit_d      = '0;
            ferr_acc_d = 1'b0;
          end
        end
        S_DATA: begin
          if (tick_q == TICK_MID) shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (bit_q == BIT_LAST) begin
              bit_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = PAR_EN ? S_PARITY : S_STOP;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_q == TICK_MID) par_bit_d = maj;
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            state_d = S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (tick_q == TICK_MID) begin
            done_ferr  = ferr_acc_q | ~maj;
            ferr_acc_d = done_ferr;
            // Leave at the last stop centre so the next start edge is not missed.
            if (bit_q == STOP_LAST) begin
              done    = 1'b1;
              state_d = S_IDLE;
              tick_d  = '0;
              bit_d   = '0;
            end
          end else if (tick_q == TICK_LAST) begin
            tick_d = '0;
            bit_d  = bit_q + 3'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d   = shift_q;
        frame_err_d = done_ferr;
        rx_valid_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_err_d = perr_calc;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      state_q     <= S_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      samp_q      <= 2'b11;
      shift_q     <= '0;
      ferr_acc_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_sync_q   <= rx_meta_q;
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      ferr_acc_q  <= ferr_acc_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
    end
  end
`endif

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign busy        = (state_q != S_IDLE);

endmodule
